// File: rtl/riscv_div_ctrl_pkg.sv
// Shared definitions for the divide control pipeline: op encodings,
// 32-bit constants and the stage-1 payload layout.
package riscv_div_ctrl_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] INT_MIN  = 32'h8000_0000;
    localparam logic [XLEN-1:0] ALL_ONES = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        OP_DIV  = 2'd0,
        OP_DIVU = 2'd1,
        OP_REM  = 2'd2,
        OP_REMU = 2'd3
    } div_op_e;

    // Operand magnitudes plus everything needed to correct the core result.
    typedef struct packed {
        logic [XLEN-1:0] a_mag;
        logic [XLEN-1:0] b_mag;
        logic [XLEN-1:0] a_orig;
        div_op_e         op;
        logic            neg_q;
        logic            neg_r;
        logic            b_zero;
        logic            ovf;
    } s1_payload_t;

    function automatic logic op_is_signed(input div_op_e op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_is_rem(input div_op_e op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/riscv_div_ctrl_fastdiv.sv
// Combinational 32-bit unsigned divider core (restoring, fully unrolled).
// Divide by zero yields quotient all-ones and remainder x.
module RiscVFastDiv
    import riscv_div_ctrl_pkg::*;
(
    input  logic [XLEN-1:0] x,
    input  logic [XLEN-1:0] y,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    logic [XLEN:0]   part;
    logic [XLEN-1:0] quo;

    always_comb begin
        part = '0;
        quo  = '0;
        for (int i = XLEN - 1; i >= 0; i--) begin
            part = {part[XLEN-1:0], x[i]};
            if (part >= {1'b0, y}) begin
                part   = part - {1'b0, y};
                quo[i] = 1'b1;
            end
        end
        quotient  = quo;
        remainder = part[XLEN-1:0];
    end

endmodule

// File: rtl/riscv_div_ctrl.sv
// Two-stage RISC-V M-extension divide/remainder pipeline with valid/ready
// handshakes, flush and special-case handling around an unsigned core.
module riscv_div_ctrl
    import riscv_div_ctrl_pkg::*;
#(
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    logic             s1_valid;
    logic             s2_valid;
    s1_payload_t      s1_pay;
    s1_payload_t      s1_nxt;
    logic [TAG_W-1:0] s1_tag;
    logic             s1_adv;
    logic             accept;
    logic [XLEN-1:0]  core_q;
    logic [XLEN-1:0]  core_r;
    logic [XLEN-1:0]  fix_q;
    logic [XLEN-1:0]  fix_r;
    logic [XLEN-1:0]  result;

    // S1 moves on when S2 is empty or is handing its result off this cycle.
    assign s1_adv    = s1_valid && (!s2_valid || out_ready);
    assign in_ready  = !rst && !flush && (!s1_valid || s1_adv);
    assign accept    = in_valid && in_ready;
    assign out_valid = s2_valid;
    assign busy      = s1_valid || s2_valid;

    // Operand conditioning ahead of the S1 register.
    always_comb begin
        logic sgn;
        s1_nxt        = '0;
        sgn           = op_is_signed(div_op_e'(in_op));
        s1_nxt.op     = div_op_e'(in_op);
        s1_nxt.a_orig = in_a;
        s1_nxt.a_mag  = (sgn && in_a[XLEN-1]) ? (~in_a + 32'd1) : in_a;
        s1_nxt.b_mag  = (sgn && in_b[XLEN-1]) ? (~in_b + 32'd1) : in_b;
        s1_nxt.b_zero = (in_b == '0);
        s1_nxt.neg_q  = sgn && (in_a[XLEN-1] != in_b[XLEN-1]) && (in_b != '0);
        s1_nxt.neg_r  = sgn && in_a[XLEN-1];
        s1_nxt.ovf    = sgn && (in_a == INT_MIN) && (in_b == ALL_ONES);
    end

    RiscVFastDiv u_core (
        .x         (s1_pay.a_mag),
        .y         (s1_pay.b_mag),
        .quotient  (core_q),
        .remainder (core_r)
    );

    // Sign correction and special cases ahead of the S2 register.
    always_comb begin
        fix_q = s1_pay.neg_q ? (~core_q + 32'd1) : core_q;
        fix_r = s1_pay.neg_r ? (~core_r + 32'd1) : core_r;
        if (s1_pay.b_zero) begin
            result = op_is_rem(s1_pay.op) ? s1_pay.a_orig : ALL_ONES;
        end else if (s1_pay.ovf) begin
            result = op_is_rem(s1_pay.op) ? '0 : INT_MIN;
        end else begin
            result = op_is_rem(s1_pay.op) ? fix_r : fix_q;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            s1_pay <= s1_nxt;
            s1_tag <= in_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
            if (s1_adv) begin
                s2_valid   <= 1'b1;
                out_result <= result;
                out_tag    <= s1_tag;
            end else if (out_ready) begin
                s2_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_riscv_div_ctrl.sv
// Directed self-checking bench for riscv_div_ctrl.
module tb_riscv_div_ctrl;

    localparam int unsigned TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    int checks = 0;
    int failures = 0;

    riscv_div_ctrl #(.TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [TAG_W-1:0] tag);
        in_valid = v;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
    endtask

    // Single op through an idle pipe with the consumer always ready.
    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [TAG_W-1:0] tag,
                          input logic [31:0] exp);
        drive(1'b1, op, a, b, tag);
        step();
        drive(1'b0, 2'd0, '0, '0, '0);
        check({name, "_lat1_valid"}, 32'(out_valid), 32'd0);
        step();
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check({name, "_result"}, out_result, exp);
        check({name, "_tag"}, 32'(out_tag), 32'(tag));
        step();
    endtask

    // Tables for the back-to-back test.
    logic [1:0]  bb_op  [4] = '{2'd1, 2'd3, 2'd0, 2'd2};
    logic [31:0] bb_a   [4] = '{32'd10, 32'd10, 32'hFFFF_FFF7, 32'd9};
    logic [31:0] bb_b   [4] = '{32'd3, 32'd3, 32'd3, 32'hFFFF_FFFC};
    logic [31:0] bb_exp [4] = '{32'd3, 32'd1, 32'hFFFF_FFFD, 32'd1};

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 2'd0, '0, '0, '0);

        step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        run_op("div_neg7_2",    2'd0, 32'hFFFF_FFF9, 32'd2, 5'd1, 32'hFFFF_FFFD);
        run_op("rem_neg7_2",    2'd2, 32'hFFFF_FFF9, 32'd2, 5'd2, 32'hFFFF_FFFF);
        run_op("divu_7_0",      2'd1, 32'd7, 32'd0, 5'd3, 32'hFFFF_FFFF);
        run_op("remu_7_0",      2'd3, 32'd7, 32'd0, 5'd4, 32'd7);
        run_op("rem_neg5_0",    2'd2, 32'hFFFF_FFFB, 32'd0, 5'd5, 32'hFFFF_FFFB);
        run_op("div_neg5_0",    2'd0, 32'hFFFF_FFFB, 32'd0, 5'd6, 32'hFFFF_FFFF);
        run_op("div_ovf",       2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 32'h8000_0000);
        run_op("rem_ovf",       2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'd0);
        run_op("divu_ovf_ops",  2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'd0);
        run_op("div_100_neg7",  2'd0, 32'd100, 32'hFFFF_FFF9, 5'd10, 32'hFFFF_FFF2);
        run_op("rem_100_neg7",  2'd2, 32'd100, 32'hFFFF_FFF9, 5'd11, 32'd2);
        run_op("divu_max_2",    2'd1, 32'hFFFF_FFFF, 32'd2, 5'd12, 32'h7FFF_FFFF);
        run_op("remu_100_7",    2'd3, 32'd100, 32'd7, 5'd13, 32'd2);

        // Back-to-back: result i appears right after accept edge i+1.
        for (int i = 0; i < 6; i++) begin
            if (i < 4) drive(1'b1, bb_op[i], bb_a[i], bb_b[i], TAG_W'(16 + i));
            else       drive(1'b0, 2'd0, '0, '0, '0);
            step();
            if (i >= 1 && i <= 4) begin
                check($sformatf("b2b%0d_valid", i - 1), 32'(out_valid), 32'd1);
                check($sformatf("b2b%0d_result", i - 1), out_result, bb_exp[i - 1]);
                check($sformatf("b2b%0d_tag", i - 1), 32'(out_tag), 32'(16 + i - 1));
            end
        end
        check("b2b_drained", 32'(out_valid), 32'd0);

        // Backpressure: three ops offered, two held, third stalled.
        out_ready = 1'b0;
        drive(1'b1, 2'd1, 32'd20, 32'd6, 5'd5);
        step();
        drive(1'b1, 2'd3, 32'd20, 32'd6, 5'd6);
        step();
        drive(1'b1, 2'd0, 32'd20, 32'hFFFF_FFFA, 5'd7);
        #1;
        check("stall_in_ready", 32'(in_ready), 32'd0);
        step();
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_result_a", out_result, 32'd3);
        check("stall_in_ready2", 32'(in_ready), 32'd0);
        step();
        check("stall_hold_result", out_result, 32'd3);
        check("stall_hold_tag", 32'(out_tag), 32'd5);
        out_ready = 1'b1;
        #1;
        check("stall_release_ready", 32'(in_ready), 32'd1);
        step();
        drive(1'b0, 2'd0, '0, '0, '0);
        check("drain_b_valid", 32'(out_valid), 32'd1);
        check("drain_b_result", out_result, 32'd2);
        check("drain_b_tag", 32'(out_tag), 32'd6);
        step();
        check("drain_c_valid", 32'(out_valid), 32'd1);
        check("drain_c_result", out_result, 32'hFFFF_FFFD);
        check("drain_c_tag", 32'(out_tag), 32'd7);
        step();
        check("drain_empty", 32'(out_valid), 32'd0);
        check("drain_busy", 32'(busy), 32'd0);

        // Flush with both stages occupied; the same-cycle request is dropped.
        out_ready = 1'b0;
        drive(1'b1, 2'd1, 32'd9, 32'd3, 5'd1);
        step();
        drive(1'b1, 2'd1, 32'd8, 32'd2, 5'd2);
        step();
        check("pre_flush_busy", 32'(busy), 32'd1);
        flush = 1'b1;
        drive(1'b1, 2'd1, 32'd6, 32'd2, 5'd3);
        #1;
        check("flush_in_ready", 32'(in_ready), 32'd0);
        step();
        flush = 1'b0;
        drive(1'b0, 2'd0, '0, '0, '0);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_busy", 32'(busy), 32'd0);
        out_ready = 1'b1;
        step();
        check("flush_no_accept", 32'(out_valid), 32'd0);

        // Reset mid-operation.
        drive(1'b1, 2'd1, 32'd9, 32'd3, 5'd4);
        step();
        drive(1'b1, 2'd1, 32'd8, 32'd2, 5'd5);
        step();
        drive(1'b0, 2'd0, '0, '0, '0);
        check("pre_rst_result", out_result, 32'd3);
        rst = 1'b1;
        step();
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_result", out_result, 32'd0);
        check("mid_rst_tag", 32'(out_tag), 32'd0);
        rst = 1'b0;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        step();
        check("mid_rst_quiet", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
